// File: rtl/int_ctrl_pkg.sv
// Shared constants for the eight-line prioritised interrupt controller.
package int_ctrl_pkg;

    // Number of interrupt lines handled by the controller.
    localparam int unsigned INT_W = 8;

    // One-hot vector used by the CU for ALU overflow entry (line 0).
    localparam logic [INT_W-1:0] INT_OVF = 8'h01;

    // Default enable mask: every external line enabled; bit 0 is don't-care.
    localparam logic [INT_W-1:0] MASK_RST_DEF = 8'hFE;

    // Line 0 never takes an external request edge.
    localparam logic [INT_W-1:0] EXT_LINES = 8'hFE;

endpackage : int_ctrl_pkg

// File: rtl/int_ctrl_lsb_onehot.sv
// Lowest-set-bit isolator: returns a one-hot copy of the least significant
// set bit of the input, or all zeros when the input is zero. Lower index
// means higher interrupt priority, so this picks the most urgent line.
import int_ctrl_pkg::*;

module lsb_onehot (
    input  logic [INT_W-1:0] data_in,
    output logic [INT_W-1:0] onehot
);

    logic [INT_W-1:0] neg_s;

    // Two's complement negate; AND with the original keeps only the lowest one.
    always_comb begin
        neg_s  = ~data_in + 8'd1;
        onehot = data_in & neg_s;
    end

endmodule : lsb_onehot

// File: rtl/int_ctrl.sv
// Eight-line prioritised interrupt controller.
// Latches rising edges of irq[7:1] into pending, gates them with a writable
// enable mask, and tracks nested in-service interrupts driven by the CU's
// accept (s_calli) and return (s_reti) vectors.
// Optional build macro: INT_CTRL_SYNC_EN adds a 2-flop synchroniser on
// irq[7:1] ahead of the edge detector (request latency +2 cycles). Without
// it, irq must already be synchronous to clk.
import int_ctrl_pkg::*;

module int_ctrl #(
    parameter logic [INT_W-1:0] MASK_RST = MASK_RST_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [INT_W-1:0] irq,
    input  logic [INT_W-1:0] s_calli,
    input  logic [INT_W-1:0] s_reti,
    input  logic             mask_we,
    input  logic [INT_W-1:0] mask_wdata,
    output logic [INT_W-1:0] min_bit_s,
    output logic [INT_W-1:0] min_bit_a,
    output logic [INT_W-1:0] pending,
    output logic [INT_W-1:0] in_service,
    output logic [INT_W-1:0] mask
);

    logic [INT_W-1:0] irq_s;
    logic [INT_W-1:0] irq_q_r;
    logic [INT_W-1:0] rise_s;
    logic [INT_W-1:0] pending_r;
    logic [INT_W-1:0] pending_nxt_s;
    logic [INT_W-1:0] in_service_r;
    logic [INT_W-1:0] in_service_nxt_s;
    logic [INT_W-1:0] mask_r;
    logic [INT_W-1:0] mask_nxt_s;
    logic [INT_W-1:0] req_enabled_s;

`ifdef INT_CTRL_SYNC_EN
    logic [INT_W-1:1] sync1_r;
    logic [INT_W-1:1] sync2_r;

    // Two-stage synchroniser for the asynchronous external request lines.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 7'd0;
            sync2_r <= 7'd0;
        end else begin
            sync1_r <= irq[INT_W-1:1];
            sync2_r <= sync1_r;
        end
    end

    // Line 0 is reserved for overflow and never sampled from irq.
    always_comb begin
        irq_s = {sync2_r, 1'b0};
    end
`else
    // Requests are already synchronous; line 0 is reserved and forced low.
    always_comb begin
        irq_s = {irq[INT_W-1:1], 1'b0};
    end
`endif

    // Previous sample of the request lines for rising-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q_r <= 8'h00;
        end else begin
            irq_q_r <= irq_s;
        end
    end

    // Next-state logic: a new edge beats an accept so no request is lost,
    // and an accept beats a return for the same line.
    always_comb begin
        rise_s           = irq_s & ~irq_q_r & EXT_LINES;
        pending_nxt_s    = (pending_r & ~s_calli) | rise_s;
        in_service_nxt_s = (in_service_r & ~s_reti) | s_calli;
        if (mask_we) begin
            mask_nxt_s = mask_wdata;
        end else begin
            mask_nxt_s = mask_r;
        end
    end

    // Controller state: pending requests, nested in-service levels, mask.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_r    <= 8'h00;
            in_service_r <= 8'h00;
            mask_r       <= MASK_RST;
        end else begin
            pending_r    <= pending_nxt_s;
            in_service_r <= in_service_nxt_s;
            mask_r       <= mask_nxt_s;
        end
    end

    // Mask only gates presentation; mask bit 0 is stored but never used.
    always_comb begin
        req_enabled_s = pending_r & mask_r & EXT_LINES;
    end

    lsb_onehot u_min_s (
        .data_in (req_enabled_s),
        .onehot  (min_bit_s)
    );

    lsb_onehot u_min_a (
        .data_in (in_service_r),
        .onehot  (min_bit_a)
    );

    assign pending    = pending_r;
    assign in_service = in_service_r;
    assign mask       = mask_r;

endmodule : int_ctrl

// File: tb/tb_int_ctrl.sv
// Directed, table-driven bench for int_ctrl. Each table row drives one cycle
// of strobes, then holds irq for the synchroniser latency before checking.
module tb_int_ctrl;

`ifdef INT_CTRL_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    typedef struct {
        logic [7:0] irq;
        logic [7:0] calli;
        logic [7:0] reti;
        logic       mwe;
        logic [7:0] mwdata;
        logic [7:0] e_pend;
        logic [7:0] e_ins;
        logic [7:0] e_mask;
        logic [7:0] e_min_s;
        logic [7:0] e_min_a;
    } vec_t;

    localparam int NV = 22;

    logic       clk;
    logic       reset;
    logic [7:0] irq;
    logic [7:0] s_calli;
    logic [7:0] s_reti;
    logic       mask_we;
    logic [7:0] mask_wdata;
    logic [7:0] min_bit_s;
    logic [7:0] min_bit_a;
    logic [7:0] pending;
    logic [7:0] in_service;
    logic [7:0] mask;

    int checks;
    int errors;
    vec_t vecs [NV];

    int_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .s_calli    (s_calli),
        .s_reti     (s_reti),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .min_bit_s  (min_bit_s),
        .min_bit_a  (min_bit_a),
        .pending    (pending),
        .in_service (in_service),
        .mask       (mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] ep, input logic [7:0] ei,
                             input logic [7:0] em, input logic [7:0] es, input logic [7:0] ea);
        check({tag, ".pending"},    pending,    ep);
        check({tag, ".in_service"}, in_service, ei);
        check({tag, ".mask"},       mask,       em);
        check({tag, ".min_bit_s"},  min_bit_s,  es);
        check({tag, ".min_bit_a"},  min_bit_a,  ea);
    endtask

    initial begin
        //          irq    calli  reti   we    wdata  pend   ins    mask   min_s  min_a
        vecs[0]  = '{8'hFF, 8'h00, 8'h00, 1'b0, 8'h00, 8'hFE, 8'h00, 8'hFE, 8'h02, 8'h00};
        vecs[1]  = '{8'hFF, 8'hFE, 8'h00, 1'b0, 8'h00, 8'h00, 8'hFE, 8'hFE, 8'h00, 8'h02};
        vecs[2]  = '{8'h00, 8'h00, 8'hFE, 1'b0, 8'h00, 8'h00, 8'h00, 8'hFE, 8'h00, 8'h00};
        vecs[3]  = '{8'h20, 8'h00, 8'h00, 1'b0, 8'h00, 8'h20, 8'h00, 8'hFE, 8'h20, 8'h00};
        vecs[4]  = '{8'h04, 8'h00, 8'h00, 1'b0, 8'h00, 8'h24, 8'h00, 8'hFE, 8'h04, 8'h00};
        vecs[5]  = '{8'h00, 8'h04, 8'h00, 1'b0, 8'h00, 8'h20, 8'h04, 8'hFE, 8'h20, 8'h04};
        vecs[6]  = '{8'h00, 8'h20, 8'h00, 1'b0, 8'h00, 8'h00, 8'h24, 8'hFE, 8'h00, 8'h04};
        vecs[7]  = '{8'h00, 8'h00, 8'h04, 1'b0, 8'h00, 8'h00, 8'h20, 8'hFE, 8'h00, 8'h20};
        vecs[8]  = '{8'h00, 8'h02, 8'h00, 1'b0, 8'h00, 8'h00, 8'h22, 8'hFE, 8'h00, 8'h02};
        vecs[9]  = '{8'h00, 8'h00, 8'h02, 1'b0, 8'h00, 8'h00, 8'h20, 8'hFE, 8'h00, 8'h20};
        vecs[10] = '{8'h00, 8'h00, 8'h08, 1'b0, 8'h00, 8'h00, 8'h20, 8'hFE, 8'h00, 8'h20};
        vecs[11] = '{8'h00, 8'h00, 8'h20, 1'b0, 8'h00, 8'h00, 8'h00, 8'hFE, 8'h00, 8'h00};
        vecs[12] = '{8'h00, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[13] = '{8'h08, 8'h00, 8'h00, 1'b0, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[14] = '{8'h00, 8'h00, 8'h00, 1'b1, 8'h08, 8'h08, 8'h00, 8'h08, 8'h08, 8'h00};
        vecs[15] = '{8'h00, 8'h08, 8'h00, 1'b0, 8'h00, 8'h00, 8'h08, 8'h08, 8'h00, 8'h08};
        vecs[16] = '{8'h00, 8'h00, 8'h00, 1'b1, 8'hFE, 8'h00, 8'h08, 8'hFE, 8'h00, 8'h08};
        vecs[17] = '{8'h10, 8'h10, 8'h00, 1'b0, 8'h00, 8'h10, 8'h18, 8'hFE, 8'h10, 8'h08};
        vecs[18] = '{8'h00, 8'h01, 8'h00, 1'b0, 8'h00, 8'h10, 8'h19, 8'hFE, 8'h10, 8'h01};
        vecs[19] = '{8'h00, 8'h00, 8'h19, 1'b0, 8'h00, 8'h10, 8'h00, 8'hFE, 8'h10, 8'h00};
        vecs[20] = '{8'h00, 8'h10, 8'h10, 1'b0, 8'h00, 8'h00, 8'h10, 8'hFE, 8'h00, 8'h10};
        vecs[21] = '{8'h00, 8'h00, 8'h10, 1'b0, 8'h00, 8'h00, 8'h00, 8'hFE, 8'h00, 8'h00};

        checks     = 0;
        errors     = 0;
        reset      = 1'b0;
        irq        = 8'hFF;
        s_calli    = 8'h00;
        s_reti     = 8'h00;
        mask_we    = 1'b0;
        mask_wdata = 8'h00;

        // Reset held with all lines high: everything clear, mask at default.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all("reset", 8'h00, 8'h00, 8'hFE, 8'h00, 8'h00);
        reset = 1'b1;

        // Table: drive strobes for one edge, hold irq through sync latency.
        for (int i = 0; i < NV; i++) begin
            irq        = vecs[i].irq;
            s_calli    = vecs[i].calli;
            s_reti     = vecs[i].reti;
            mask_we    = vecs[i].mwe;
            mask_wdata = vecs[i].mwdata;
            @(posedge clk);
            #1;
            s_calli = 8'h00;
            s_reti  = 8'h00;
            mask_we = 1'b0;
            repeat (LAT) @(posedge clk);
            @(negedge clk);
            check_all($sformatf("vec%0d", i), vecs[i].e_pend, vecs[i].e_ins,
                      vecs[i].e_mask, vecs[i].e_min_s, vecs[i].e_min_a);
        end

        // Mid-operation reset drops pending and in-service state.
        irq = 8'h40;
        repeat (LAT + 1) @(posedge clk);
        s_calli = 8'h80;
        @(posedge clk);
        #1;
        s_calli = 8'h00;
        @(negedge clk);
        check("pre_reset.pending", pending, 8'h40);
        check("pre_reset.in_service", in_service, 8'h80);
        irq   = 8'h00;
        reset = 1'b0;
        #2;
        check_all("mid_reset", 8'h00, 8'h00, 8'hFE, 8'h00, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("idle.pending", pending, 8'h00);

        // Request latency: min_bit_s appears exactly LAT+1 edges after the rise.
        irq = 8'h02;
        for (int e = 1; e <= LAT + 2; e++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("latency_e%0d", e), min_bit_s, (e >= LAT + 1) ? 8'h02 : 8'h00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_int_ctrl
